branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Downstream consumer of the ALU compare stage: takes the eq/lt/ltu flags and a conditional-branch instruction's PC, immediate and funct3.
- Decides taken/not-taken, computes the target, and handshakes a redirect to fetch.
- Holds a flush window so the wrong-path instructions already fetched are squashed.
- Sits between the ALU compare outputs and the fetch/control logic of the RV32I core.

Parameters:
- XLEN, 32, data/address width.
- FLUSH_CYCLES, 2, cycles flush_o stays high after a redirect is accepted; 0 means no flush window.

Ports:
- clk_i  in  1  core clock
- rstn_i  in  1  asynchronous active-low reset
- valid_i  in  1  branch request valid
- ready_o  out  1  unit can accept a request
- funct3_i  in  3  branch funct3 (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU)
- cmp_eq_i  in  1  rs1 == rs2
- cmp_lt_i  in  1  rs1 < rs2, signed (bit 0 of the signed comparator result)
- cmp_ltu_i  in  1  rs1 < rs2, unsigned (bit 0 of the unsigned comparator result)
- pc_i  in  XLEN  PC of the branch
- imm_i  in  XLEN  sign-extended B-immediate
- done_o  out  1  one-cycle pulse: resolution complete
- taken_o  out  1  valid with done_o: branch taken
- illegal_o  out  1  one-cycle pulse: funct3 is 010 or 011
- misalign_o  out  1  one-cycle pulse: taken target not 4-byte aligned
- redirect_valid_o  out  1  redirect request to fetch
- redirect_addr_o  out  XLEN  redirect target
- redirect_ready_i  in  1  fetch accepts the redirect
- flush_o  out  1  squash wrong-path instructions

Behaviour:
- Reset (async, rstn_i=0):
  - state=IDLE.
  - All pulses, redirect_valid_o and flush_o go to 0.
  - redirect_addr_o=0; captured registers=0.
  - ready_o=1 after reset.
  - Reset mid-operation discards the request and drops redirect_valid_o and flush_o immediately.
- FSM states: IDLE, EVAL, REDIRECT, FLUSH.
- IDLE:
  - ready_o=1.
  - On valid_i&ready_o, register funct3, the three flags and pc+imm (XLEN-bit add, wrap modulo 2^XLEN, no carry out). Go to EVAL.
  - ready_o=0 in every state other than IDLE.
- EVAL (exactly one cycle; done_o=1 here, so resolution latency is 1 cycle after acceptance):
  - Taken condition per funct3: BEQ eq; BNE !eq; BLT lt; BGE !lt; BLTU ltu; BGEU !ltu.
  - funct3 010/011: illegal_o=1, taken_o=0, next IDLE.
  - Not taken: taken_o=0, next IDLE.
  - Taken and target[1:0]!=0: taken_o=1, misalign_o=1, no redirect, next IDLE.
  - Taken and aligned: taken_o=1, next REDIRECT; redirect_addr_o loaded with the target.
- REDIRECT:
  - redirect_valid_o=1 and redirect_addr_o held stable until redirect_ready_i=1.
  - On the handshake cycle: if FLUSH_CYCLES>0, go to FLUSH and load the counter with FLUSH_CYCLES; else go to IDLE.
- FLUSH:
  - flush_o=1; counter decrements each cycle.
  - Exit to IDLE in the cycle the counter reaches 1, so flush_o is high for exactly FLUSH_CYCLES cycles.
  - Counter width is clog2(FLUSH_CYCLES+1), minimum 1.
- taken_o is 0 whenever done_o is 0.
- Flag inputs are sampled only at acceptance; later changes have no effect.
- A new request arriving while the unit is busy is not accepted (ready_o=0). Upstream holds it.
- Back-to-back requests: the earliest the next acceptance can happen is the cycle after EVAL, for the not-taken path.

Decomposition:
- Shared package (core_pkg):
  - XLEN.
  - funct3 branch encodings (BEQ..BGEU).
  - state enum encoding: IDLE=0, EVAL=1, REDIRECT=2, FLUSH=3.
- Natural sub-module: branch_cond_eval, combinational, taking funct3 and the flags and producing taken and illegal.
- FSM, adder and flush counter stay in the top.

Test Plan:
- BEQ, eq=1, pc=0x100, imm=0x20, redirect_ready_i=1 immediately, FLUSH_CYCLES=2 -> done_o and taken_o one cycle after accept; redirect_addr_o=0x120 handshakes the next cycle; flush_o high exactly 2 cycles; ready_o=1 again after that.
- BLTU, ltu=0 (and BGE, lt=1) -> done_o=1, taken_o=0, no redirect_valid_o, no flush_o; next request accepted the cycle after EVAL.
- BNE, eq=0, pc=0x0, imm=0xFFFFFFFC -> target wraps to 0xFFFFFFFC; redirect_valid_o held stable for 5 cycles with redirect_ready_i=0; handshake on cycle 6.
- funct3=011 -> illegal_o pulse, taken_o=0. Taken BGEU (ltu=0) with pc=0x100, imm=0x6 -> misalign_o pulse, no redirect.
- rstn_i asserted mid-REDIRECT, then mid-FLUSH -> redirect_valid_o and flush_o drop asynchronously; ready_o=1 after rstn_i is released.
- FLUSH_CYCLES=0 build, taken BLT -> IDLE directly after the handshake; flush_o never asserts.

Source files
------------

// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the RV32I branch resolution path: the data/address
// width, the conditional-branch funct3 encodings and the state encoding used
// by branch_resolve_unit.
// -----------------------------------------------------------------------------
package core_pkg;

  // Data and address width of the core.
  localparam int XLEN = 32;

  // Conditional-branch funct3 encodings (opcode BRANCH).
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Branch resolution FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EVAL     = 2'd1,
    REDIRECT = 2'd2,
    FLUSH    = 2'd3
  } bru_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// -----------------------------------------------------------------------------
// branch_cond_eval
// Combinational branch-condition decoder. Turns a branch funct3 plus the ALU
// comparator flags into a taken decision, and flags the two funct3 values that
// are not valid conditional branches.
//
// Ports:
//   funct3_i   branch funct3
//   eq_i       rs1 == rs2
//   lt_i       rs1 <  rs2, signed
//   ltu_i      rs1 <  rs2, unsigned
//   taken_o    branch condition holds (always 0 for an illegal funct3)
//   illegal_o  funct3 is 010 or 011
// -----------------------------------------------------------------------------
module branch_cond_eval
  import core_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       eq_i,
  input  logic       lt_i,
  input  logic       ltu_i,
  output logic       taken_o,
  output logic       illegal_o
);

  // Each legal funct3 selects one flag, optionally inverted. Anything else is
  // reported as illegal and never taken.
  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  taken_o = eq_i;
      F3_BNE:  taken_o = ~eq_i;
      F3_BLT:  taken_o = lt_i;
      F3_BGE:  taken_o = ~lt_i;
      F3_BLTU: taken_o = ltu_i;
      F3_BGEU: taken_o = ~ltu_i;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Resolves RV32I conditional branches after the ALU compare stage. A request
// is captured in IDLE together with its precomputed target (pc + imm), the
// decision is reported one cycle later in EVAL, a taken and aligned branch
// then handshakes a redirect with fetch, and an optional flush window squashes
// the wrong-path instructions already in flight.
//
// Parameters:
//   XLEN          data/address width
//   FLUSH_CYCLES  cycles flush_o is held after an accepted redirect (0 = none)
//
// Ports:
//   clk_i             core clock
//   rstn_i            asynchronous active-low reset
//   valid_i/ready_o   request handshake
//   funct3_i          branch funct3
//   cmp_eq_i          rs1 == rs2
//   cmp_lt_i          rs1 <  rs2, signed
//   cmp_ltu_i         rs1 <  rs2, unsigned
//   pc_i, imm_i       branch PC and sign-extended B-immediate
//   done_o            one-cycle pulse when the decision is available
//   taken_o           branch taken, qualified by done_o
//   illegal_o         one-cycle pulse: funct3 010/011
//   misalign_o        one-cycle pulse: taken target not 4-byte aligned
//   redirect_valid_o  redirect request to fetch
//   redirect_addr_o   redirect target, stable while redirect_valid_o is high
//   redirect_ready_i  fetch accepts the redirect
//   flush_o           squash wrong-path instructions
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int XLEN         = core_pkg::XLEN,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      funct3_i,
  input  logic            cmp_eq_i,
  input  logic            cmp_lt_i,
  input  logic            cmp_ltu_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  output logic            done_o,
  output logic            taken_o,
  output logic            illegal_o,
  output logic            misalign_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_addr_o,
  input  logic            redirect_ready_i,
  output logic            flush_o
);

  import core_pkg::*;

  // The counter must be able to hold FLUSH_CYCLES; a zero-length window still
  // keeps a one-bit counter so the logic stays well formed.
  localparam int CNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  bru_state_e      state_q, state_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            eq_q, eq_d;
  logic            lt_q, lt_d;
  logic            ltu_q, ltu_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            cond_taken;
  logic            cond_illegal;
  logic            target_misaligned;

  // Condition decoding works on the captured copies, so flag changes after
  // acceptance cannot affect the decision.
  branch_cond_eval u_cond_eval (
    .funct3_i  (funct3_q),
    .eq_i      (eq_q),
    .lt_i      (lt_q),
    .ltu_i     (ltu_q),
    .taken_o   (cond_taken),
    .illegal_o (cond_illegal)
  );

  assign target_misaligned = (target_q[1:0] != 2'b00);

  // State and captured-request registers. Reset clears everything, which also
  // drops redirect_valid_o and flush_o immediately since they decode state.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      funct3_q <= '0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      ltu_q    <= 1'b0;
      target_q <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
      ltu_q    <= ltu_d;
      target_q <= target_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic. The target is added at capture time so EVAL only has to
  // look at its low bits; the add wraps modulo 2^XLEN by construction.
  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    ltu_d    = ltu_q;
    target_d = target_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          funct3_d = funct3_i;
          eq_d     = cmp_eq_i;
          lt_d     = cmp_lt_i;
          ltu_d    = cmp_ltu_i;
          target_d = pc_i + imm_i;
          state_d  = EVAL;
        end
      end
      EVAL: begin
        if (cond_taken && !cond_illegal && !target_misaligned) begin
          addr_d  = target_q;
          state_d = REDIRECT;
        end else begin
          state_d = IDLE;
        end
      end
      REDIRECT: begin
        if (redirect_ready_i) begin
          if (FLUSH_CYCLES > 0) begin
            cnt_d   = CNT_W'(FLUSH_CYCLES);
            state_d = FLUSH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        // Leaving while the counter reads 1 gives exactly FLUSH_CYCLES cycles
        // of flush_o; the <= also recovers if the counter were ever 0.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode directly from state so they react to reset at once.
  always_comb begin
    ready_o          = (state_q == IDLE);
    done_o           = (state_q == EVAL);
    taken_o          = done_o & cond_taken & ~cond_illegal;
    illegal_o        = done_o & cond_illegal;
    misalign_o       = done_o & cond_taken & ~cond_illegal & target_misaligned;
    redirect_valid_o = (state_q == REDIRECT);
    redirect_addr_o  = addr_q;
    flush_o          = (state_q == FLUSH);
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
// Scoreboard bench for branch_resolve_unit. Requests are derived from actual
// rs1/rs2 operand values; the reference model decides branches from those
// operands directly and queues the expected decision and redirect. A monitor
// checks every done pulse, redirect and flush window against the queues. A
// second instance built with FLUSH_CYCLES=0 is checked with a directed run.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;

  logic        valid = 1'b0;
  logic [2:0]  funct3 = '0;
  logic        cmpEq = 1'b0, cmpLt = 1'b0, cmpLtu = 1'b0;
  logic [31:0] pcIn = '0, immIn = '0;
  logic        redirectReady = 1'b0;
  logic        ready, done, taken, illegal, misalign, redirectValid, flush;
  logic [31:0] redirectAddr;

  logic        valid1 = 1'b0;
  logic [2:0]  funct31 = '0;
  logic        cmpEq1 = 1'b0, cmpLt1 = 1'b0, cmpLtu1 = 1'b0;
  logic [31:0] pcIn1 = '0, immIn1 = '0;
  logic        redirectReady1 = 1'b0;
  logic        ready1, done1, taken1, illegal1, misalign1, redirectValid1, flush1;
  logic [31:0] redirectAddr1;

  typedef struct {
    logic        taken;
    logic        illegal;
    logic        misalign;
    logic        redirect;
    logic [31:0] addr;
    int          acceptCyc;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] redirQ[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          rrRandom = 1'b0;
  logic        rrForce = 1'b0;
  int          flushRun = 0;
  bit          flushDue = 1'b0;
  bit          flushExpect = 1'b0;
  bit          flush1Seen = 1'b0;

  branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
    .clk_i(clk), .rstn_i(rstn), .valid_i(valid), .ready_o(ready),
    .funct3_i(funct3), .cmp_eq_i(cmpEq), .cmp_lt_i(cmpLt), .cmp_ltu_i(cmpLtu),
    .pc_i(pcIn), .imm_i(immIn), .done_o(done), .taken_o(taken),
    .illegal_o(illegal), .misalign_o(misalign),
    .redirect_valid_o(redirectValid), .redirect_addr_o(redirectAddr),
    .redirect_ready_i(redirectReady), .flush_o(flush)
  );

  branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(0)) dutNoFlush (
    .clk_i(clk), .rstn_i(rstn), .valid_i(valid1), .ready_o(ready1),
    .funct3_i(funct31), .cmp_eq_i(cmpEq1), .cmp_lt_i(cmpLt1), .cmp_ltu_i(cmpLtu1),
    .pc_i(pcIn1), .imm_i(immIn1), .done_o(done1), .taken_o(taken1),
    .illegal_o(illegal1), .misalign_o(misalign1),
    .redirect_valid_o(redirectValid1), .redirect_addr_o(redirectAddr1),
    .redirect_ready_i(redirectReady1), .flush_o(flush1)
  );

  // Free-running clock and posedge counter used for latency checks.
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Fetch-side ready changes just after the edge so it is stable at negedge.
  always @(posedge clk) begin
    #1;
    redirectReady = rrRandom ? 1'($urandom_range(0, 1)) : rrForce;
  end

  // The FLUSH_CYCLES=0 instance must never raise flush_o.
  always @(negedge clk) if (flush1) flush1Seen = 1'b1;

  // Hard time limit so the bench always terminates.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Reference model: branch decision straight from operand values.
  function automatic exp_t refModel(input logic [2:0] f3, input logic [31:0] rs1,
                                    input logic [31:0] rs2, input logic [31:0] pc,
                                    input logic [31:0] imm);
    exp_t r;
    logic [31:0] tgt;
    r.taken   = 1'b0;
    r.illegal = 1'b0;
    case (f3)
      3'b000:  r.taken = (rs1 == rs2);
      3'b001:  r.taken = (rs1 != rs2);
      3'b100:  r.taken = ($signed(rs1) <  $signed(rs2));
      3'b101:  r.taken = ($signed(rs1) >= $signed(rs2));
      3'b110:  r.taken = (rs1 <  rs2);
      3'b111:  r.taken = (rs1 >= rs2);
      default: r.illegal = 1'b1;
    endcase
    tgt         = pc + imm;
    r.addr      = tgt;
    r.misalign  = r.taken && ((tgt & 32'h3) != 0);
    r.redirect  = r.taken && !r.misalign;
    r.acceptCyc = 0;
    return r;
  endfunction

  // Present a request (called at a negedge) and hold it until accepted.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] rs1,
                               input logic [31:0] rs2, input logic [31:0] pc,
                               input logic [31:0] imm, output int acc);
    exp_t e;
    acc    = -1;
    valid  = 1'b1;
    funct3 = f3;
    cmpEq  = (rs1 == rs2);
    cmpLt  = ($signed(rs1) < $signed(rs2));
    cmpLtu = (rs1 < rs2);
    pcIn   = pc;
    immIn  = imm;
    for (int i = 0; i < 60; i++) begin
      if (ready) begin
        e = refModel(f3, rs1, rs2, pc, imm);
        e.acceptCyc = cyc + 1;
        expQ.push_back(e);
        acc = e.acceptCyc;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got ready=0 for 60 cycles expected ready=1");
    end else begin
      @(negedge clk);
    end
    valid  = 1'b0;
    funct3 = 3'($urandom);
    cmpEq  = 1'($urandom);
    cmpLt  = 1'($urandom);
    cmpLtu = 1'($urandom);
    pcIn   = $urandom;
    immIn  = $urandom;
  endtask

  task automatic waitQuiet(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ready && expQ.size() == 0 && redirQ.size() == 0 && !flushExpect &&
          flushRun == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL quiet_timeout: got busy after %0d cycles expected idle", budget);
    end
  endtask

  task automatic waitFor(input string name, input bit wantFlush, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (wantFlush ? flush : redirectValid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got no assertion in %0d cycles expected 1", name, budget);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse and tracks redirect
  // handshakes and flush windows.
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      expQ.delete();
      redirQ.delete();
      flushRun    = 0;
      flushDue    = 1'b0;
      flushExpect = 1'b0;
    end else begin
      if (done) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got done=1 expected no pending request");
        end else begin
          e = expQ.pop_front();
          checkOutput("taken", 32'(taken), 32'(e.taken));
          checkOutput("illegal", 32'(illegal), 32'(e.illegal));
          checkOutput("misalign", 32'(misalign), 32'(e.misalign));
          checkOutput("latency", 32'(cyc), 32'(e.acceptCyc));
          if (e.redirect) redirQ.push_back(e.addr);
        end
      end else begin
        checkOutput("pulse_without_done", 32'({taken, illegal, misalign}), 32'd0);
      end

      if (done || redirectValid || flush)
        checkOutput("ready_while_busy", 32'(ready), 32'd0);

      if (flushDue) begin
        checkOutput("flush_start", 32'(flush), 32'd1);
        flushDue = 1'b0;
      end
      if (flush) begin
        flushRun++;
        if (flushRun == 1) checkOutput("flush_expected", 32'(flushExpect), 32'd1);
      end else if (flushRun > 0) begin
        checkOutput("flush_len", 32'(flushRun), 32'd2);
        checkOutput("ready_after_flush", 32'(ready), 32'd1);
        flushRun    = 0;
        flushExpect = 1'b0;
      end

      if (redirectValid) begin
        if (redirQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_redirect: got redirect to 0x%08h expected none",
                   redirectAddr);
        end else begin
          checkOutput("redirect_addr", redirectAddr, redirQ[0]);
          if (redirectReady) begin
            void'(redirQ.pop_front());
            flushDue    = 1'b1;
            flushExpect = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int acc, acc1, acc2;
    logic [31:0] rs1, rs2, pc, imm;
    logic [2:0]  f3;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 32'(ready), 32'd1);
    checkOutput("rst_outputs", 32'({done, taken, illegal, misalign, redirectValid, flush}), 32'd0);
    checkOutput("rst_addr", redirectAddr, 32'd0);
    #2 rstn = 1'b1;
    @(negedge clk);

    // Taken BEQ, immediate redirect acceptance, 2-cycle flush.
    rrForce = 1'b1;
    @(negedge clk);
    applyStimulus(F3_BEQ, 32'd5, 32'd5, 32'h100, 32'h20, acc);
    waitQuiet(40);

    // Not-taken BLTU then BGE back to back.
    applyStimulus(F3_BLTU, 32'd10, 32'd3, 32'h200, 32'h40, acc1);
    checkOutput("busy_in_eval", 32'(ready), 32'd0);
    applyStimulus(F3_BGE, 32'hFFFF_FFFF, 32'd0, 32'h300, 32'h40, acc2);
    checkOutput("back_to_back", 32'(acc2), 32'(acc1 + 2));
    waitQuiet(40);

    // BNE with wrapping target and a 5-cycle fetch stall.
    rrForce = 1'b0;
    @(negedge clk);
    applyStimulus(F3_BNE, 32'd1, 32'd2, 32'h0, 32'hFFFF_FFFC, acc);
    waitFor("redirect_seen", 1'b0, 10);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("stall_hold", 32'(redirectValid), 32'd1);
    end
    rrForce = 1'b1;
    @(negedge clk);
    checkOutput("handshake_cycle6", 32'({redirectValid, redirectReady}), 32'd3);
    waitQuiet(40);

    // Illegal funct3 values and a misaligned taken BGEU.
    applyStimulus(3'b011, 32'd1, 32'd1, 32'h100, 32'h8, acc);
    applyStimulus(3'b010, 32'd1, 32'd2, 32'h100, 32'h8, acc);
    applyStimulus(F3_BGEU, 32'd5, 32'd5, 32'h100, 32'h6, acc);
    waitQuiet(40);

    // Reset in the middle of REDIRECT.
    rrForce = 1'b0;
    @(negedge clk);
    applyStimulus(F3_BEQ, 32'd7, 32'd7, 32'h40, 32'h10, acc);
    waitFor("redirect_before_rst", 1'b0, 10);
    #2 rstn = 1'b0;
    #1;
    checkOutput("rst_drops_redirect", 32'(redirectValid), 32'd0);
    checkOutput("rst_clears_addr", redirectAddr, 32'd0);
    @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_rst1", 32'(ready), 32'd1);

    // Reset in the middle of FLUSH.
    rrForce = 1'b1;
    @(negedge clk);
    applyStimulus(F3_BEQ, 32'd9, 32'd9, 32'h80, 32'h10, acc);
    waitFor("flush_before_rst", 1'b1, 10);
    #2 rstn = 1'b0;
    #1;
    checkOutput("rst_drops_flush", 32'(flush), 32'd0);
    @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_rst2", 32'(ready), 32'd1);

    // FLUSH_CYCLES=0 instance: taken BLT returns to IDLE after the handshake.
    redirectReady1 = 1'b1;
    checkOutput("nf_ready", 32'(ready1), 32'd1);
    valid1 = 1'b1; funct31 = F3_BLT; cmpEq1 = 1'b0; cmpLt1 = 1'b1; cmpLtu1 = 1'b0;
    pcIn1 = 32'h200; immIn1 = 32'h40;
    @(negedge clk);
    valid1 = 1'b0; cmpLt1 = 1'b0;
    checkOutput("nf_done_taken", 32'({done1, taken1}), 32'd3);
    @(negedge clk);
    checkOutput("nf_redirect", 32'(redirectValid1), 32'd1);
    checkOutput("nf_addr", redirectAddr1, 32'h240);
    @(negedge clk);
    checkOutput("nf_idle_after", 32'({ready1, redirectValid1, flush1}), 32'd4);

    // Randomized traffic with random fetch back-pressure.
    rrRandom = 1'b1;
    for (int n = 0; n < 150; n++) begin
      f3  = 3'($urandom);
      rs1 = $urandom;
      case ($urandom_range(0, 2))
        0:       rs2 = rs1;
        1:       rs2 = $urandom;
        default: rs2 = rs1 ^ 32'h8000_0000;
      endcase
      pc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) imm = $urandom & 32'hFFFF_FFFE;
      else imm = ($urandom & 32'h0000_1FFC) | ($urandom_range(0, 1) ? 32'hFFFF_E000 : 32'h0);
      applyStimulus(f3, rs1, rs2, pc, imm, acc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    waitQuiet(200);
    rrRandom = 1'b0;

    checkOutput("queues_empty", 32'(expQ.size() + redirQ.size()), 32'd0);
    checkOutput("nf_never_flushed", 32'(flush1Seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
